// File: rtl/shift_pkg.sv
// Shared types and width helpers for the shift-register family (PISO and friends).
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } piso_state_t;

  // Bit-index width for a WIDTH-bit word; never below one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int PISO_WIDTH = 4;
  localparam int CNT_W      = cnt_width(PISO_WIDTH);

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// WIDTH-modulo bit-index counter with synchronous clear, enable and a terminal flag.
module bit_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW   = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          term
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  assign term = (count == LAST);

  // Clear wins over enable so a new frame always starts at index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= term ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: one word per valid/ready handshake, one bit per clk.
// Optional even-parity trailer cycle when PISO_PARITY_EN is defined.
module piso_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: a word is taken at a posedge where load_valid and load_ready are both 1;
  // load_ready depends only on state, never combinationally on load_valid.

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  piso_state_t     state, state_nxt;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]   count;
  logic [CW-1:0]   idx;
  logic            term;
  logic            count_en;
  logic            accept;

  assign accept    = load_valid & load_ready;
  assign state_dbg = state;
  assign idx       = (MSB_FIRST != 0) ? (LAST - count) : count;

  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (count_en),
    .count (count),
    .term  (term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      word  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) word <= i;
    end
  end

  // The word is held for the whole frame; the bit counter selects the outgoing bit.
  always_comb begin
    state_nxt  = state;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load_ready = 1'b0;
    count_en   = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        sout       = word[idx];
        sout_valid = 1'b1;
        busy       = 1'b1;
        count_en   = 1'b1;
        if (term) begin
`ifdef PISO_PARITY_EN
          state_nxt = PAR;
`else
          done       = 1'b1;
          load_ready = 1'b1;
          state_nxt  = load_valid ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        sout       = ^word;
        sout_valid = 1'b1;
        busy       = 1'b1;
        done       = 1'b1;
        load_ready = 1'b1;
        state_nxt  = load_valid ? SHIFT : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule
